// File: rtl/skin_bbox_tracker.sv
// rtl/skin_bbox_tracker.sv - per-frame skin bounding box and pixel count over the eroded mask stream
// Optional SKIN_BBOX_HOLD_EN: box outputs keep the previous values on frames without a detection.
module skin_bbox_tracker #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int XW         = 9,
    parameter int YW         = 8,
    parameter int CW         = 17,
    parameter int MIN_PIXELS = 16
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          iDATA,
    input  logic          iDVAL,
    input  logic          iSOF,
    output logic [XW-1:0] oXMIN,
    output logic [XW-1:0] oXMAX,
    output logic [YW-1:0] oYMIN,
    output logic [YW-1:0] oYMAX,
    output logic [CW-1:0] oCOUNT,
    output logic          oFOUND,
    output logic          oVALID,
    output logic          oERR
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [XW-1:0] LAST_X = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(V_ACTIVE - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic [XW-1:0] rxmin_q, rxmin_d, rxmax_q, rxmax_d;
    logic [YW-1:0] rymin_q, rymin_d, rymax_q, rymax_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rfound_q, rfound_d;
    logic          err_q, err_d;
    logic          pix, found;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        rxmin_d  = rxmin_q;
        rxmax_d  = rxmax_q;
        rymin_d  = rymin_q;
        rymax_d  = rymax_q;
        rcnt_d   = rcnt_q;
        rfound_d = rfound_q;
        err_d    = 1'b0;
        found    = 1'b0;
        pix      = iDVAL && (iSOF || state_q == ACTIVE);

        if (iSOF) begin
            // Restarting after pixels were accepted throws away a partial frame
            err_d   = (state_q == ACTIVE) && seen_q;
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            xmin_d  = '1;
            xmax_d  = '0;
            ymin_d  = '1;
            ymax_d  = '0;
            cnt_d   = '0;
            seen_d  = 1'b0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end

        if (pix) begin
            seen_d = 1'b1;
            if (iDATA) begin
                if (x_d < xmin_d) xmin_d = x_d;
                if (x_d > xmax_d) xmax_d = x_d;
                if (y_d < ymin_d) ymin_d = y_d;
                if (y_d > ymax_d) ymax_d = y_d;
                if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
            end
            if (x_d == LAST_X && y_d == LAST_Y) begin
                found    = int'(cnt_d) >= MIN_PIXELS;
                rcnt_d   = cnt_d;
                rfound_d = found;
                if (found) begin
                    rxmin_d = xmin_d;
                    rxmax_d = xmax_d;
                    rymin_d = ymin_d;
                    rymax_d = ymax_d;
                end else begin
`ifdef SKIN_BBOX_HOLD_EN
                    rxmin_d = rxmin_q;
                    rxmax_d = rxmax_q;
                    rymin_d = rymin_q;
                    rymax_d = rymax_q;
`else
                    rxmin_d = '0;
                    rxmax_d = '0;
                    rymin_d = '0;
                    rymax_d = '0;
`endif
                end
                state_d = DONE;
                x_d     = '0;
                y_d     = '0;
            end else if (x_d == LAST_X) begin
                x_d = '0;
                y_d = y_d + 1'b1;
            end else begin
                x_d = x_d + 1'b1;
            end
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            xmin_q   <= '1;
            xmax_q   <= '0;
            ymin_q   <= '1;
            ymax_q   <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            rxmin_q  <= '0;
            rxmax_q  <= '0;
            rymin_q  <= '0;
            rymax_q  <= '0;
            rcnt_q   <= '0;
            rfound_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            rxmin_q  <= rxmin_d;
            rxmax_q  <= rxmax_d;
            rymin_q  <= rymin_d;
            rymax_q  <= rymax_d;
            rcnt_q   <= rcnt_d;
            rfound_q <= rfound_d;
            err_q    <= err_d;
        end
    end

    assign oXMIN  = rxmin_q;
    assign oXMAX  = rxmax_q;
    assign oYMIN  = rymin_q;
    assign oYMAX  = rymax_q;
    assign oCOUNT = rcnt_q;
    assign oFOUND = rfound_q;
    assign oVALID = (state_q == DONE);
    assign oERR   = err_q;
endmodule

// File: tb/tb_skin_bbox_tracker.sv
// tb/tb_skin_bbox_tracker.sv - randomized checks of skin_bbox_tracker against a frame-array model
module tb_skin_bbox_tracker;
    localparam int H = 8;
    localparam int V = 4;
    localparam int NPIX = H * V;

    typedef struct {
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
        bit found;
    } res_t;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    logic iDATA = 1'b0, iDVAL = 1'b0, iSOF = 1'b0;

    logic [2:0]  oXMIN_a, oXMAX_a, oXMIN_b, oXMAX_b;
    logic [1:0]  oYMIN_a, oYMAX_a, oYMIN_b, oYMAX_b;
    logic [16:0] oCOUNT_a;
    logic [2:0]  oCOUNT_b;
    logic        oFOUND_a, oVALID_a, oERR_a, oFOUND_b, oVALID_b, oERR_b;

    int compared = 0;
    int mismatched = 0;
    int va_a = 0, va_b = 0, er_a = 0;
    bit mask [NPIX];
    res_t prev_a, prev_b;

    wire [28:0] obs_a = {oVALID_a, oFOUND_a, oCOUNT_a, oXMIN_a, oXMAX_a, oYMIN_a, oYMAX_a};
    wire [14:0] obs_b = {oVALID_b, oFOUND_b, oCOUNT_b, oXMIN_b, oXMAX_b, oYMIN_b, oYMAX_b};

    skin_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(3), .YW(2), .CW(17), .MIN_PIXELS(2)) dut_a (
        .iclk(iclk), .irst(irst), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
        .oXMIN(oXMIN_a), .oXMAX(oXMAX_a), .oYMIN(oYMIN_a), .oYMAX(oYMAX_a),
        .oCOUNT(oCOUNT_a), .oFOUND(oFOUND_a), .oVALID(oVALID_a), .oERR(oERR_a));

    skin_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(3), .YW(2), .CW(3), .MIN_PIXELS(1)) dut_b (
        .iclk(iclk), .irst(irst), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
        .oXMIN(oXMIN_b), .oXMAX(oXMAX_b), .oYMIN(oYMIN_b), .oYMAX(oYMAX_b),
        .oCOUNT(oCOUNT_b), .oFOUND(oFOUND_b), .oVALID(oVALID_b), .oERR(oERR_b));

    always #5 iclk = ~iclk;

    always @(negedge iclk) begin
        va_a += int'(oVALID_a);
        va_b += int'(oVALID_b);
        er_a += int'(oERR_a);
    end

    function automatic res_t zero_res();
        res_t r;
        r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0; r.cnt = 0; r.found = 1'b0;
        return r;
    endfunction

    // Expected frame result straight from the mask array.
    function automatic res_t model(input int cw, input int minp, input res_t prev);
        res_t r;
        int n = 0, x0 = H, x1 = -1, y0 = V, y1 = -1;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (mask[y*H+x]) begin
                    n++;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
        r.cnt   = (n > (1 << cw) - 1) ? (1 << cw) - 1 : n;
        r.found = (r.cnt >= minp);
        if (r.found) begin
            r.xmin = x0; r.xmax = x1; r.ymin = y0; r.ymax = y1;
        end else begin
`ifdef SKIN_BBOX_HOLD_EN
            r.xmin = prev.xmin; r.xmax = prev.xmax; r.ymin = prev.ymin; r.ymax = prev.ymax;
`else
            r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0;
`endif
        end
        return r;
    endfunction

    function automatic logic [28:0] pack_a(input res_t r);
        return {1'b1, r.found, 17'(r.cnt), 3'(r.xmin), 3'(r.xmax), 2'(r.ymin), 2'(r.ymax)};
    endfunction

    function automatic logic [14:0] pack_b(input res_t r);
        return {1'b1, r.found, 3'(r.cnt), 3'(r.xmin), 3'(r.xmax), 2'(r.ymin), 2'(r.ymax)};
    endfunction

    task automatic drive(input bit sof, input bit dval, input bit data);
        @(negedge iclk); #1;
        iSOF = sof; iDVAL = dval; iDATA = data;
    endtask

    // sof_mode: 0 already active, 1 separate iSOF cycle, 2 iSOF with first pixel.
    // gap_mode: 0 none, 1 alternate, 2 random blanking. Returns one cycle after the last pixel.
    task automatic run_frame(input int sof_mode, input int gap_mode);
        if (sof_mode == 1) drive(1'b1, 1'b0, 1'b0);
        for (int p = 0; p < NPIX; p++) begin
            if (gap_mode == 2)
                while ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            drive((sof_mode == 2) && (p == 0), 1'b1, mask[p]);
            if (gap_mode == 1 && p != NPIX - 1) drive(1'b0, 1'b0, 1'b1);
        end
        @(negedge iclk); #1;
    endtask

    task automatic set_mask(input int a, input int b, input int c);
        for (int i = 0; i < NPIX; i++) mask[i] = (i == a) || (i == b) || (i == c);
    endtask

    task automatic test_reset();
        irst = 1'b1;
        repeat (3) @(negedge iclk);
        #1;
        compared++;
        if (obs_a !== '0 || oERR_a !== 1'b0) begin
            mismatched++; $display("FAIL reset_a obs=%h err=%b exp=0", obs_a, oERR_a);
        end
        compared++;
        if (obs_b !== '0) begin
            mismatched++; $display("FAIL reset_b obs=%h exp=0", obs_b);
        end
        irst = 1'b0;
        prev_a = zero_res(); prev_b = zero_res();
    endtask

    task automatic test_frame(input string name, input int sof_mode, input int gap_mode, input int exp_err);
        res_t ea, eb;
        int va0 = va_a, vb0 = va_b, e0 = er_a;
        ea = model(17, 2, prev_a);
        eb = model(3, 1, prev_b);
        run_frame(sof_mode, gap_mode);
        compared++;
        if (obs_a !== pack_a(ea)) begin
            mismatched++; $display("FAIL %s_a obs=%h exp=%h", name, obs_a, pack_a(ea));
        end
        compared++;
        if (obs_b !== pack_b(eb)) begin
            mismatched++; $display("FAIL %s_b obs=%h exp=%h", name, obs_b, pack_b(eb));
        end
        compared++;
        if (va_a - va0 != 1 || va_b - vb0 != 1 || er_a - e0 != exp_err) begin
            mismatched++;
            $display("FAIL %s_pulses valid=%0d/%0d err=%0d exp valid=1/1 err=%0d",
                     name, va_a - va0, va_b - vb0, er_a - e0, exp_err);
        end
        prev_a = ea; prev_b = eb;
    endtask

    task automatic test_basic();
        set_mask(1*H+2, 1*H+5, 2*H+3);
        test_frame("basic", 1, 0, 0);
        iSOF = 1'b0; iDVAL = 1'b0; iDATA = 1'b0;
    endtask

    task automatic test_last_pixel();
        set_mask(NPIX - 1, NPIX - 1, NPIX - 1);
        test_frame("last_pixel", 2, 0, 0);
        iSOF = 1'b0; iDVAL = 1'b0; iDATA = 1'b0;
    endtask

    task automatic test_gaps();
        for (int i = 0; i < NPIX; i++) mask[i] = 1'b1;
        test_frame("gaps", 1, 1, 0);
        iSOF = 1'b0; iDVAL = 1'b0; iDATA = 1'b0;
    endtask

    task automatic test_abort();
        drive(1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 10; p++) drive(1'b0, 1'b1, 1'b1);
        set_mask(4, 4, 4);
        test_frame("abort", 2, 0, 1);
        iSOF = 1'b0; iDVAL = 1'b0; iDATA = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int va0;
        drive(1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 20; p++) drive(1'b0, 1'b1, 1'b1);
        @(negedge iclk); #1;
        irst = 1'b1; iDVAL = 1'b0;
        @(negedge iclk); #1;
        irst = 1'b0;
        va0 = va_a;
        for (int p = 20; p < NPIX; p++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge iclk);
        #1;
        compared++;
        if (obs_a !== '0 || obs_b !== '0 || va_a != va0) begin
            mismatched++;
            $display("FAIL rst_mid obs_a=%h obs_b=%h valid=%0d exp 0/0/0", obs_a, obs_b, va_a - va0);
        end
        prev_a = zero_res(); prev_b = zero_res();
        for (int i = 0; i < NPIX; i++) mask[i] = 1'($urandom_range(0, 1));
        test_frame("rst_mid_next", 1, 2, 0);
        iSOF = 1'b0; iDVAL = 1'b0; iDATA = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit b2b = 1'b0;
        for (int f = 0; f < 10; f++) begin
            int dens = $urandom_range(0, 100);
            for (int i = 0; i < NPIX; i++) mask[i] = ($urandom_range(0, 99) < dens);
            test_frame("random", b2b ? 0 : int'($urandom_range(1, 2)), 2, 0);
            b2b = (f != 9) && ($urandom_range(0, 1) == 1);
            iSOF = b2b; iDVAL = 1'b0; iDATA = 1'b0;
        end
    endtask

    task automatic test_idle_dval();
        int va0 = va_a;
        for (int p = 0; p < 40; p++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge iclk); #1;
        compared++;
        if (obs_a !== {1'b0, pack_a(prev_a)[27:0]} || va_a != va0) begin
            mismatched++;
            $display("FAIL idle_dval obs=%h exp=%h valid=%0d", obs_a, {1'b0, pack_a(prev_a)[27:0]}, va_a - va0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last_pixel();
        test_gaps();
        test_abort();
        test_reset_midframe();
        test_back_to_back();
        test_idle_dval();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/skin_bbox_tracker.md
Name: skin_bbox_tracker

Overview:
- Downstream of the 3x3 erosion stage, on the same binary skin-mask pixel stream.
- Consumes the eroded mask (one bit per pixel, qualified by a data-valid strobe) and tracks the frame raster position.
- Accumulates the bounding box and the total count of skin pixels per frame.
- Publishes a registered result set once per frame with a one-cycle valid pulse, for the overlay/box-drawing logic.

Parameters:
- H_ACTIVE, 320, active pixels per line
- V_ACTIVE, 240, active lines per frame
- XW, 9, x coordinate width; must satisfy 2^XW > H_ACTIVE-1
- YW, 8, y coordinate width; must satisfy 2^YW > V_ACTIVE-1
- CW, 17, skin pixel counter width
- MIN_PIXELS, 16, minimum skin pixel count for a frame to report a detection

Ports:
- iclk  in  1  system clock; all logic on the rising edge
- irst  in  1  asynchronous, active-high reset
- iDATA  in  1  eroded mask bit; 1 = skin; sampled only when iDVAL=1
- iDVAL  in  1  pixel qualifier; one pixel per cycle while high
- iSOF  in  1  start-of-frame pulse, one cycle, before or coincident with the first pixel
- oXMIN  out  XW  leftmost skin column of the last completed frame
- oXMAX  out  XW  rightmost skin column
- oYMIN  out  YW  top skin line
- oYMAX  out  YW  bottom skin line
- oCOUNT  out  CW  skin pixel count, saturating
- oFOUND  out  1  1 when oCOUNT >= MIN_PIXELS
- oVALID  out  1  one-cycle pulse; result outputs updated
- oERR  out  1  one-cycle pulse; frame aborted because iSOF arrived mid-frame

Behaviour:
- Reset (irst=1, asynchronous): all outputs 0; x/y counters 0; accumulators cleared; state IDLE.
- States:
  - IDLE: iDVAL ignored; iSOF moves to ACTIVE.
  - ACTIVE: pixels are counted and accumulated.
  - DONE: one cycle; oVALID=1; then moves to IDLE.
- Raster counters:
  - x increments on each iDVAL in ACTIVE.
  - At x=H_ACTIVE-1, x wraps to 0 and y increments.
  - The last pixel is x=H_ACTIVE-1, y=V_ACTIVE-1.
- Accumulators:
  - Cleared at iSOF to xmin=all-ones, xmax=0, ymin=all-ones, ymax=0, cnt=0.
  - On iDVAL & iDATA, update xmin/xmax/ymin/ymax by comparison.
  - cnt increments and saturates at 2^CW-1; there is no wrap.
- Result commit:
  - On the edge that samples the last pixel, the outputs register the final values, including that pixel's contribution.
  - The state goes to DONE, so oVALID is high for exactly the following cycle.
  - Outputs hold until the next commit.
- Detection result:
  - cnt >= MIN_PIXELS: oFOUND=1; box outputs carry the accumulated values.
  - cnt < MIN_PIXELS: oFOUND=0; box outputs are zero (see Optional Feature); oCOUNT is still the true count.
- iSOF coincident with iDVAL: that pixel is x=0, y=0 of the new frame and is accumulated.
- iSOF in ACTIVE after at least one pixel:
  - oERR pulses for one cycle and the partial frame is discarded, with no oVALID.
  - Accumulators and counters restart and the state stays ACTIVE.
- iSOF in ACTIVE before any pixel: treated as a plain restart, with no oERR.
- iSOF during DONE: oVALID still pulses, and the new frame begins in the same cycle.
- iDVAL with no preceding iSOF (IDLE): ignored; no state change.
- Gaps in iDVAL: freeze the counters; blanking of any length is tolerated.
- irst mid-frame: all progress discarded; outputs return to 0.

Optional Feature:
- Macro: SKIN_BBOX_HOLD_EN.
- Defined: when a frame commits with oFOUND=0, oXMIN/oXMAX/oYMIN/oYMAX keep the previous frame's values. oCOUNT and oFOUND still update, and oVALID still pulses. This stops the overlay box flickering on brief dropouts.
- Undefined: the box outputs are forced to 0 on frames with oFOUND=0.

Test Plan:
- Params H=8, V=4, MIN=2. iSOF, then 32 pixels with skin at (2,1), (5,1), (3,2) -> one cycle after the last pixel: oVALID=1, XMIN=2, XMAX=5, YMIN=1, YMAX=2, COUNT=3, FOUND=1.
- Same params, a single skin pixel at (7,3), the very last pixel -> COUNT=1, FOUND=0, box=0 (macro off); box holds the previous values (macro on).
- All 32 pixels skin, with iDVAL toggled 1/0 every cycle -> XMIN=0, XMAX=7, YMIN=0, YMAX=3, COUNT=32; oVALID comes exactly once.
- iSOF after 10 pixels -> oERR=1 for one cycle and no oVALID. The next full frame with skin at (4,0) only and MIN=1 reports XMIN=XMAX=4, YMIN=YMAX=0.
- CW=3, all 32 pixels skin -> COUNT=7 (saturated), FOUND per MIN.
- irst asserted at pixel 20 and then released, with the frame continuing but no new iSOF -> no oVALID; outputs stay 0 until a new iSOF and a complete frame.
